key_cmd_sched: RTL and testbench

//   Round-robin scheduler that turns debounced key presses into motor commands.

---
 rtl/key_cmd_sched.sv | 138 +++++++++++++
 tb/tb_key_cmd_sched.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_sched.sv
// Round-robin scheduler: latches debounced key presses as pending requests and
// issues them one at a time to a motor controller, with a cmd_done watchdog.
module key_cmd_sched #(
  parameter int NUM_KEYS    = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic [NUM_KEYS-1:0] key_value,
  output logic                cmd_valid,
  output logic [ID_W-1:0]     cmd_id,
  input  logic                cmd_ready,
  input  logic                cmd_done,
  output logic                busy,
  output logic [NUM_KEYS-1:0] pend_mask,
  output logic                timeout_err
);

  localparam int                CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [ID_W-1:0]     cmd_id_q, cmd_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_KEYS-1:0] pend_q, pend_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] clr_mask;

  // First set bit of req at or after start, wrapping; caller guarantees req != 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_KEYS-1:0] req,
                                              input logic [ID_W-1:0]     start);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  assign press = key_flag & ~key_value;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_id_d      = cmd_id_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    clr_mask      = '0;

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          cmd_id_d    = rr_pick(pend_q, rr_ptr_q);
          cmd_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          clr_mask    = {{(NUM_KEYS-1){1'b0}}, 1'b1} << cmd_id_q;
          cmd_valid_d = 1'b0;
          rr_ptr_d    = (cmd_id_q == LAST_ID) ? '0 : cmd_id_q + ID_W'(1);
          cnt_d       = '0;
          state_d     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // A done arriving in the expiry cycle still counts as a clean finish.
        if (cmd_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear before set so a press landing on its own accept cycle re-arms the key.
    pend_d = (pend_q & ~clr_mask) | press;
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      cmd_valid_q   <= 1'b0;
      cmd_id_q      <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      pend_q        <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_id_q      <= cmd_id_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_id      = cmd_id_q;
  assign busy        = busy_q;
  assign pend_mask   = pend_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Self-checking bench for key_cmd_sched: directed scenarios plus random traffic,
// checked per cycle against a transaction-level reference model and a grant scoreboard.
module tb_key_cmd_sched;

  localparam int NK = 4;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_flag;
  logic [NK-1:0] key_value;
  logic          cmd_valid;
  logic [1:0]    cmd_id;
  logic          cmd_ready;
  logic          cmd_done;
  logic          busy;
  logic [NK-1:0] pend_mask;
  logic          timeout_err;

  key_cmd_sched #(.NUM_KEYS(NK), .ID_W(2), .TIMEOUT_CYC(TO)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .cmd_valid   (cmd_valid),
    .cmd_id      (cmd_id),
    .cmd_ready   (cmd_ready),
    .cmd_done    (cmd_done),
    .busy        (busy),
    .pend_mask   (pend_mask),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int { PH_IDLE, PH_OFFERED, PH_WAITING } phase_e;

  phase_e        m_phase;
  logic [NK-1:0] m_pend;
  int            m_rr;
  int            m_id;
  int            m_waited;
  logic          m_tout;
  int            exp_q[$];

  task automatic m_reset();
    m_phase  = PH_IDLE;
    m_pend   = '0;
    m_rr     = 0;
    m_id     = 0;
    m_waited = 0;
    m_tout   = 1'b0;
    exp_q.delete();
  endtask

  task automatic m_step();
    logic [NK-1:0] presses;
    logic [NK-1:0] kept;
    bit            found;
    presses = key_flag & ~key_value;
    kept    = m_pend;
    m_tout  = 1'b0;
    case (m_phase)
      PH_IDLE: if (m_pend != 0) begin
        found = 0;
        for (int k = 0; k < NK; k++) begin
          if (!found && m_pend[(m_rr + k) % NK]) begin
            found = 1;
            m_id  = (m_rr + k) % NK;
          end
        end
        exp_q.push_back(m_id);
        m_phase = PH_OFFERED;
      end
      PH_OFFERED: if (cmd_ready) begin
        kept[m_id] = 1'b0;
        m_rr       = (m_id + 1) % NK;
        m_waited   = 0;
        m_phase    = PH_WAITING;
      end
      PH_WAITING: begin
        m_waited++;
        if (cmd_done) m_phase = PH_IDLE;
        else if (m_waited == TO) begin
          m_tout  = 1'b1;
          m_phase = PH_IDLE;
        end
      end
      default: m_phase = PH_IDLE;
    endcase
    m_pend = kept | presses;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        check("pend_mask",   32'(pend_mask),   32'(m_pend));
        check("busy",        32'(busy),        32'(m_phase != PH_IDLE));
        check("cmd_valid",   32'(cmd_valid),   32'(m_phase == PH_OFFERED));
        check("cmd_id",      32'(cmd_id),      m_id);
        check("timeout_err", 32'(timeout_err), 32'(m_tout));
        if (cmd_valid && !prev_valid) begin
          if (exp_q.size() == 0) check("grant_unexpected", 32'(cmd_id), 32'hffff_ffff);
          else                   check("grant_id", 32'(cmd_id), exp_q.pop_front());
        end
        prev_valid = cmd_valid;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input logic [NK-1:0] f, input logic [NK-1:0] v,
                      input logic r, input logic d);
    key_flag  = f;
    key_value = v;
    cmd_ready = r;
    cmd_done  = d;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, output logic [1:0] id);
    int n;
    n = 0;
    while (!cmd_valid && n < 40) begin
      tick('0, '0, 1'b0, 1'b0);
      n++;
    end
    check({tag, "_valid_seen"}, 32'(cmd_valid), 32'd1);
    id = cmd_id;
  endtask

  task automatic serve(input int done_delay);
    tick('0, '0, 1'b1, 1'b0);
    repeat (done_delay) tick('0, '0, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] gid;
  int         tout_at;
  int         seen;

  initial begin
    rst_n     = 1'b0;
    key_flag  = '0;
    key_value = '0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_pend",      32'(pend_mask), 32'd0);
    rst_n = 1'b1;
    tick('0, '0, 1'b0, 1'b0);

    // Release events must not create requests.
    tick(4'b0001, 4'b0001, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    check("rel_pend",  32'(pend_mask), 32'd0);
    check("rel_valid", 32'(cmd_valid), 32'd0);
    repeat (3) tick('0, '0, 1'b0, 1'b0);

    // Round robin over keys 0,1,3, then wrap back to 0.
    tick(4'b1011, 4'b0000, 1'b0, 1'b0);
    wait_valid("rr0", gid); check("rr_first",  32'(gid), 32'd0); serve(2);
    wait_valid("rr1", gid); check("rr_second", 32'(gid), 32'd1); serve(2);
    wait_valid("rr3", gid); check("rr_third",  32'(gid), 32'd3); serve(2);
    tick(4'b1001, 4'b0000, 1'b0, 1'b0);
    wait_valid("rrw", gid); check("rr_wrap",   32'(gid), 32'd0); serve(1);
    wait_valid("rrx", gid); check("rr_after",  32'(gid), 32'd3); serve(1);
    repeat (2) tick('0, '0, 1'b0, 1'b0);

    // Single grant with exact latency and held id.
    tick(4'b0100, 4'b0000, 1'b0, 1'b0);
    check("sg_pend", 32'(pend_mask), 32'h4);
    check("sg_not_yet", 32'(cmd_valid), 32'd0);
    tick('0, '0, 1'b0, 1'b0);
    check("sg_valid", 32'(cmd_valid), 32'd1);
    check("sg_id",    32'(cmd_id),    32'd2);
    repeat (3) begin
      tick('0, '0, 1'b0, 1'b0);
      check("sg_hold_id", 32'(cmd_id), 32'd2);
    end
    tick('0, '0, 1'b1, 1'b0);
    check("sg_acc_pend", 32'(pend_mask), 32'd0);
    check("sg_acc_busy", 32'(busy),      32'd1);
    tick('0, '0, 1'b0, 1'b1);
    check("sg_done_busy", 32'(busy), 32'd0);
    check("sg_id_kept",   32'(cmd_id), 32'd2);

    // Done arriving in the expiry cycle wins over the watchdog.
    tick(4'b0001, 4'b0000, 1'b0, 1'b0);
    wait_valid("col", gid);
    serve(TO - 1);
    check("col_no_tout", 32'(timeout_err), 32'd0);
    check("col_idle",    32'(busy),        32'd0);
    tick('0, '0, 1'b0, 1'b0);
    check("col_no_tout_late", 32'(timeout_err), 32'd0);

    // Press of key 1 during its own accept cycle re-arms it.
    tick(4'b0010, 4'b0000, 1'b0, 1'b0);
    wait_valid("rearm", gid); check("rearm_id", 32'(gid), 32'd1);
    tick(4'b0010, 4'b0000, 1'b1, 1'b0);
    check("rearm_pend", 32'(pend_mask), 32'h2);
    tick('0, '0, 1'b0, 1'b1);
    wait_valid("rearm2", gid); check("rearm_reissue", 32'(gid), 32'd1);
    serve(0);

    // Watchdog: no done; pulse 16 cycles after accept, then next pending key.
    tick(4'b0100, 4'b0000, 1'b0, 1'b0);
    wait_valid("wd", gid); check("wd_id", 32'(gid), 32'd2);
    tick('0, '0, 1'b1, 1'b0);
    tout_at = -1;
    for (int k = 1; k <= TO + 4 && tout_at < 0; k++) begin
      tick((k == 1) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, 1'b0);
      if (timeout_err) tout_at = k;
    end
    check("wd_latency", tout_at, TO);
    check("wd_idle",    32'(busy), 32'd0);
    tick('0, '0, 1'b0, 1'b0);
    check("wd_pulse_one", 32'(timeout_err), 32'd0);
    wait_valid("wd_next", gid); check("wd_next_id", 32'(gid), 32'd0);
    serve(3);

    // Asynchronous reset mid-WAIT_DONE with pending keys.
    tick(4'b0001, 4'b0000, 1'b0, 1'b0);
    wait_valid("ar", gid);
    tick('0, '0, 1'b1, 1'b0);
    tick(4'b1010, 4'b0000, 1'b0, 1'b0);
    tick('0, '0, 1'b0, 1'b0);
    check("ar_pend_pre", 32'(pend_mask), 32'ha);
    check("ar_busy_pre", 32'(busy),      32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(cmd_valid),   32'd0);
    check("ar_id",    32'(cmd_id),      32'd0);
    check("ar_busy",  32'(busy),        32'd0);
    check("ar_pend",  32'(pend_mask),   32'd0);
    check("ar_tout",  32'(timeout_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick('0, '0, 1'b1, 1'b1);
      if (cmd_valid) seen++;
    end
    check("ar_quiet", seen, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [NK-1:0] f;
      logic [NK-1:0] v;
      f = NK'($urandom) & NK'($urandom) & NK'($urandom);
      v = NK'($urandom);
      tick(f, v, 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
    end
    repeat (60) tick('0, '0, 1'b1, 1'b1);
    check("sb_drained", exp_q.size(), 0);
    check("end_idle",   32'(busy),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
